// File: rtl/xb_out_port.sv
// Output-side unit for one router output port: registers the crossbar flit onto the link and tracks per-VC credits and allocation state.
// Define OUT_PORT_ERR_CHECK_EN to build the sticky protocol-error detector; without it err is tied low.

module xb_out_vc #(
  parameter int CREDIT_DEPTH = 4,
  parameter int CW           = $clog2(CREDIT_DEPTH+1)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flit_hit,
  input  logic [1:0] flit_type,
  input  logic       credit_hit,
  output logic       credit_avail,
  output logic       vc_free,
  output logic       err_evt
);
  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  localparam logic [1:0] FT_BODY = 2'b00, FT_HEAD = 2'b01, FT_TAIL = 2'b10, FT_SNGL = 2'b11;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          cnt_full, cnt_empty;
  logic          unf, ovf, bad_type;

  assign cnt_full     = (cnt == CW'(CREDIT_DEPTH));
  assign cnt_empty    = (cnt == '0);
  assign credit_avail = !cnt_empty;
  assign vc_free      = (state == S_IDLE);
  assign err_evt      = unf | ovf | bad_type;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= CW'(CREDIT_DEPTH);
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // A flit and a credit on this VC in the same cycle cancel out.
  always_comb begin
    cnt_nxt = cnt;
    unf     = 1'b0;
    ovf     = 1'b0;
    case ({flit_hit, credit_hit})
      2'b10: if (cnt_empty) unf = 1'b1; else cnt_nxt = cnt - CW'(1);
      2'b01: if (cnt_full)  ovf = 1'b1; else cnt_nxt = cnt + CW'(1);
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    bad_type  = 1'b0;
    case (state)
      S_IDLE: if (flit_hit) begin
        if (flit_type == FT_HEAD)      state_nxt = S_ACTIVE;
        else if (flit_type == FT_SNGL) state_nxt = S_DRAIN;
        else                           bad_type  = 1'b1;
      end
      S_ACTIVE: if (flit_hit) begin
        if (flit_type == FT_TAIL)      state_nxt = S_DRAIN;
        else if (flit_type != FT_BODY) bad_type  = 1'b1;
      end
      S_DRAIN: begin
        // Free only once every downstream slot has been returned.
        if (flit_hit)      bad_type  = 1'b1;
        else if (cnt_full) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end
endmodule

module xb_out_port #(
  parameter int DW           = 16,
  parameter int VN           = 4,
  parameter int CREDIT_DEPTH = 4,
  parameter int VC_LSB       = 0,
  parameter int FT_LSB       = 2,
  localparam int VCW         = $clog2(VN),
  localparam int CW          = $clog2(CREDIT_DEPTH+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DW-1:0]  xb_data,
  input  logic           xb_valid,
  input  logic           credit_in_valid,
  input  logic [VCW-1:0] credit_in_vc,
  output logic [DW-1:0]  link_data,
  output logic           link_valid,
  output logic [VN-1:0]  credit_avail,
  output logic [VN-1:0]  vc_free,
  output logic           err
);
  logic [VCW-1:0] flit_vc;
  logic [1:0]     flit_type;
  logic [VN-1:0]  err_evt;

  assign flit_vc   = xb_data[VC_LSB +: VCW];
  assign flit_type = xb_data[FT_LSB +: 2];

  always_ff @(posedge clk) begin
    if (rst) begin
      link_data  <= '0;
      link_valid <= 1'b0;
    end else begin
      link_data  <= xb_data;
      link_valid <= xb_valid;
    end
  end

  for (genvar v = 0; v < VN; v++) begin : g_vc
    xb_out_vc #(.CREDIT_DEPTH(CREDIT_DEPTH), .CW(CW)) u_vc (
      .clk          (clk),
      .rst          (rst),
      .flit_hit     (xb_valid && (flit_vc == VCW'(v))),
      .flit_type    (flit_type),
      .credit_hit   (credit_in_valid && (credit_in_vc == VCW'(v))),
      .credit_avail (credit_avail[v]),
      .vc_free      (vc_free[v]),
      .err_evt      (err_evt[v])
    );
  end

`ifdef OUT_PORT_ERR_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst)           err <= 1'b0;
    else if (|err_evt) err <= 1'b1;
  end
`else
  logic unused_err_evt;
  assign unused_err_evt = ^err_evt;
  assign err            = 1'b0;
`endif
endmodule

// File: tb/tb_xb_out_port.sv
// Scoreboard bench for xb_out_port: directed steps queue expectations, a negedge monitor checks them.
module tb_xb_out_port;
`ifdef OUT_PORT_ERR_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif
  localparam logic [1:0] BODY = 2'b00, HEAD = 2'b01, TAIL = 2'b10, SNGL = 2'b11;
  localparam logic [15:0] D0 = 16'h5A5A;
  localparam logic [3:0]  F  = 4'b1111;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] xb_data = '0;
  logic        xb_valid = 1'b0;
  logic        credit_in_valid = 1'b0;
  logic [1:0]  credit_in_vc = '0;
  logic [15:0] link_data;
  logic        link_valid;
  logic [3:0]  credit_avail, vc_free;
  logic        err;

  typedef struct {
    logic        lv;
    logic [15:0] ld;
    logic [3:0]  ca;
    logic [3:0]  vf;
    logic        e;
    string       nm;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  xb_out_port #(.DW(16), .VN(4), .CREDIT_DEPTH(4), .VC_LSB(0), .FT_LSB(2)) dut (
    .clk(clk), .rst(rst), .xb_data(xb_data), .xb_valid(xb_valid),
    .credit_in_valid(credit_in_valid), .credit_in_vc(credit_in_vc),
    .link_data(link_data), .link_valid(link_valid),
    .credit_avail(credit_avail), .vc_free(vc_free), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] fl(input logic [1:0] vc, input logic [1:0] ft, input logic [11:0] p);
    return {p, ft, vc};
  endfunction

  // Drive one cycle; expectation covers outputs after the next rising edge.
  task automatic step(input bit r, input bit v, input logic [15:0] d, input bit cv, input logic [1:0] cvc,
                      input logic [3:0] ca, input logic [3:0] vf, input bit e, input string nm);
    exp_t x;
    rst = r; xb_valid = v; xb_data = d; credit_in_valid = cv; credit_in_vc = cvc;
    @(posedge clk);
    x.lv = r ? 1'b0 : v;
    x.ld = r ? 16'h0 : d;
    x.ca = ca; x.vf = vf; x.e = ERR_ON ? e : 1'b0; x.nm = nm;
    q.push_back(x);
    #1;
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      total++;
      if (link_valid !== x.lv || link_data !== x.ld || credit_avail !== x.ca || vc_free !== x.vf || err !== x.e) begin
        bad++;
        $display("FAIL %s: got lv=%b ld=%h ca=%b vf=%b err=%b, want lv=%b ld=%h ca=%b vf=%b err=%b",
                 x.nm, link_valid, link_data, credit_avail, vc_free, err, x.lv, x.ld, x.ca, x.vf, x.e);
      end
    end
  end

  initial begin
    // T1 reset
    step(1, 0, D0, 0, 0, F, F, 0, "t1_reset");
    // T2 packet on VC2 then credit return and drain
    step(0, 1, fl(2, HEAD, 12'h111), 0, 0, F, 4'b1011, 0, "t2_head");
    step(0, 1, fl(2, BODY, 12'h222), 0, 0, F, 4'b1011, 0, "t2_body");
    step(0, 1, fl(2, TAIL, 12'h333), 0, 0, F, 4'b1011, 0, "t2_tail");
    step(0, 0, D0, 1, 2, F, 4'b1011, 0, "t2_cred1");
    step(0, 0, 16'h0F0F, 1, 2, F, 4'b1011, 0, "t2_cred2");
    step(0, 0, D0, 1, 2, F, 4'b1011, 0, "t2_cred3");
    step(0, 0, D0, 0, 0, F, F, 0, "t2_freed");
    // T3 credit exhaustion on VC1, underflow saturates at 0
    step(0, 1, fl(1, HEAD, 12'h401), 0, 0, F, 4'b1101, 0, "t3_head");
    step(0, 1, fl(1, BODY, 12'h402), 0, 0, F, 4'b1101, 0, "t3_body1");
    step(0, 1, fl(1, BODY, 12'h403), 0, 0, F, 4'b1101, 0, "t3_body2");
    step(0, 1, fl(1, BODY, 12'h404), 0, 0, 4'b1101, 4'b1101, 0, "t3_empty");
    step(0, 1, fl(1, BODY, 12'h405), 0, 0, 4'b1101, 4'b1101, 1, "t3_underflow");
    step(0, 0, D0, 1, 1, F, 4'b1101, 1, "t3_nowrap");
    step(1, 0, D0, 0, 0, F, F, 0, "t3_reset");
    // T4 simultaneous flit and credit
    step(0, 1, fl(0, HEAD, 12'h501), 0, 0, F, 4'b1110, 0, "t4_head");
    step(0, 1, fl(0, BODY, 12'h502), 0, 0, F, 4'b1110, 0, "t4_body");
    step(0, 1, fl(0, BODY, 12'h503), 1, 0, F, 4'b1110, 0, "t4_same_vc");
    step(0, 1, fl(0, BODY, 12'h504), 1, 3, F, 4'b1110, 1, "t4_diff_vc_ovf");
    step(0, 1, fl(0, BODY, 12'h505), 0, 0, 4'b1110, 4'b1110, 1, "t4_cnt0_was1");
    step(1, 0, D0, 0, 0, F, F, 0, "t4_reset");
    // T5 illegal types
    step(0, 1, fl(3, BODY, 12'h601), 0, 0, F, F, 1, "t5_body_idle");
    step(0, 1, fl(3, HEAD, 12'h602), 0, 0, F, 4'b0111, 1, "t5_head");
    step(0, 1, fl(3, HEAD, 12'h603), 0, 0, F, 4'b0111, 1, "t5_head_active");
    step(0, 1, fl(3, TAIL, 12'h604), 0, 0, 4'b0111, 4'b0111, 1, "t5_tail");
    step(1, 0, D0, 0, 0, F, F, 0, "t5_reset");
    // T6 reset mid-packet
    step(0, 1, fl(1, HEAD, 12'h701), 0, 0, F, 4'b1101, 0, "t6_head");
    step(1, 1, fl(1, BODY, 12'h702), 0, 0, F, F, 0, "t6_reset_mid");
    step(0, 0, D0, 0, 0, F, F, 0, "t6_after");
    rst = 0; xb_valid = 0; credit_in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
